inst_loader: RTL and testbench

- Writer-side companion to the fetch path: receives a program image as a byte stream and writes 32-bit instruction words into the instruction memory.
- Holds the core (PC register and IF/ID pipe) in reset while loading.
- Releases the core only after a complete, valid image has been written.
- Sits between the host byte link and the instruction memory write port.

---
 rtl/inst_loader_pkg.sv | 23 ++
 rtl/inst_loader_word_assembler.sv | 50 +++++
 rtl/inst_loader.sv | 147 ++++++++++++++
 tb/tb_inst_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared types and sizes for the instruction-image loader.
`default_nettype none

package inst_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        COMMIT,
        CHK,
        DONE,
        ERR
    } loader_state_t;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / 8;
    localparam int LEN_W          = 16;

endpackage

`default_nettype wire

// File: rtl/inst_loader_word_assembler.sv
// inst_loader_word_assembler: little-endian byte shift register with a byte-index
// counter; full flags the byte that completes the current word.
`default_nettype none

module inst_loader_word_assembler
    import inst_loader_pkg::*;
#(
    parameter int BYTES = BYTES_PER_WORD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [7:0]           byte_in,
    output logic [8*BYTES-1:0]   word_o,
    output logic                 full
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0]   idx;
    logic [8*BYTES-1:0] word_next;

    // Bytes enter at the top and move down, so the first byte lands in bits 7:0.
    generate
        if (BYTES > 1) begin : g_multi
            assign word_next = {byte_in, word_o[8*BYTES-1:8]};
        end else begin : g_single
            assign word_next = byte_in;
        end
    endgenerate

    assign full = shift_en && (idx == IDX_W'(BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_o <= '0;
            idx    <= '0;
        end else if (clear) begin
            word_o <= '0;
            idx    <= '0;
        end else if (shift_en) begin
            word_o <= word_next;
            idx    <= full ? '0 : idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// inst_loader: writes a length-prefixed byte-stream image into instruction memory
// and holds the core in reset until done. Optional trailing XOR byte: INST_LOADER_CHECKSUM_EN.
`default_nettype none

module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int N         = WORD_W,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [N-1:0]      mem_data_o,
    output logic              core_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    loader_state_t     state;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  words;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              can_start;
    logic              word_full;
    logic [LEN_W-1:0]  len_full;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]        chk;
`endif

    assign accept    = byte_valid_i && byte_ready_o;
    assign can_start = start_i && (state == IDLE || state == DONE || state == ERR);
    assign len_full  = {byte_data_i, count[7:0]};

    inst_loader_word_assembler #(
        .BYTES (N / 8)
    ) u_asm (
        .clk      (CLK),
        .rst_n    (RST),
        .clear    (can_start),
        .shift_en (accept && state == DATA),
        .byte_in  (byte_data_i),
        .word_o   (mem_data_o),
        .full     (word_full)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            byte_ready_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= ADDR_W'(BASE_ADDR);
            core_hold_o  <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            count        <= '0;
            words        <= '0;
            addr         <= ADDR_W'(BASE_ADDR);
`ifdef INST_LOADER_CHECKSUM_EN
            chk          <= '0;
`endif
        end else begin
            mem_we_o <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            if (accept && state != CHK) chk <= chk ^ byte_data_i;
`endif
            if (can_start) begin
                state        <= LEN_LO;
                byte_ready_o <= 1'b1;
                core_hold_o  <= 1'b1;
                busy_o       <= 1'b1;
                done_o       <= 1'b0;
                error_o      <= 1'b0;
                count        <= '0;
                words        <= '0;
                addr         <= ADDR_W'(BASE_ADDR);
`ifdef INST_LOADER_CHECKSUM_EN
                chk          <= '0;
`endif
            end else begin
                case (state)
                    LEN_LO: if (accept) begin
                        count[7:0] <= byte_data_i;
                        state      <= LEN_HI;
                    end
                    LEN_HI: if (accept) begin
                        count[15:8] <= byte_data_i;
                        if (len_full == '0) begin
                            state <= DONE; byte_ready_o <= 1'b0; busy_o <= 1'b0;
                            done_o <= 1'b1; core_hold_o <= 1'b0;
                        end else if ({1'b0, len_full} > (17'd1 << ADDR_W)) begin
                            state <= ERR; byte_ready_o <= 1'b0; busy_o <= 1'b0;
                            error_o <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: if (word_full) begin
                        state        <= COMMIT;
                        byte_ready_o <= 1'b0;
                        mem_we_o     <= 1'b1;
                        mem_addr_o   <= addr;
                    end
                    COMMIT: begin
                        addr  <= addr + 1'b1;
                        words <= words + 1'b1;
                        if (words + 1'b1 == count) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state <= CHK; byte_ready_o <= 1'b1;
`else
                            state <= DONE; busy_o <= 1'b0;
                            done_o <= 1'b1; core_hold_o <= 1'b0;
`endif
                        end else begin
                            state        <= DATA;
                            byte_ready_o <= 1'b1;
                        end
                    end
`ifdef INST_LOADER_CHECKSUM_EN
                    CHK: if (accept) begin
                        byte_ready_o <= 1'b0;
                        busy_o       <= 1'b0;
                        if (byte_data_i == chk) begin
                            state <= DONE; done_o <= 1'b1; core_hold_o <= 1'b0;
                        end else begin
                            state <= ERR; error_o <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed scoreboard bench for inst_loader (expected memory writes
// are queued by the stimulus and popped by a write monitor).
`default_nettype none

module tb_inst_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        core_hold_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    inst_loader #(.N(32), .ADDR_W(12), .BASE_ADDR(0)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .core_hold_o  (core_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every write pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (mem_we_o !== 1'b0) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected no write",
                         mem_addr_o, mem_data_o);
            end else begin
                logic [11:0] a;
                logic [31:0] d;
                a = exp_addr_q.pop_front();
                d = exp_data_q.pop_front();
                check("write_addr", 32'(mem_addr_o), 32'(a));
                check("write_data", mem_data_o, d);
            end
        end
    end

    task automatic expect_write(input logic [11:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Called and returns at a negedge; gap_max > 0 inserts random idle cycles first.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        bit ok;
        ok = 1'b0;
        g  = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        if (g > 0) begin
            byte_valid_i = 1'b0;
            repeat (g) @(negedge CLK);
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int t = 0; t < 50; t++) begin
            if (byte_ready_o) begin
                @(posedge CLK);
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (ok) @(negedge CLK);
        byte_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte 0x%02h not accepted, expected within 50 cycles", b);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_core_hold", 32'(core_hold_o), 32'd1);
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", 32'(mem_addr_o), 32'd0);
        check("rst_data", mem_data_o, 32'd0);
        check("rst_flags", {29'd0, busy_o, done_o, error_o}, 32'd0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_core_hold", 32'(core_hold_o), 32'd1);
        check("idle_ready", 32'(byte_ready_o), 32'd0);

        // Two-word image at full rate
        expect_write(12'd0, 32'h12345678);
        expect_write(12'd1, 32'hDEADBEEF);
        pulse_start();
        check("load_busy", 32'(busy_o), 32'd1);
        check("load_ready", 32'(byte_ready_o), 32'd1);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
        check("commit_latency_we", 32'(mem_we_o), 32'd1);
        check("commit_ready_low", 32'(byte_ready_o), 32'd0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        check("commit2_we", 32'(mem_we_o), 32'd1);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'h28, 0);
`else
        @(negedge CLK);
`endif
        check("img1_done", 32'(done_o), 32'd1);
        check("img1_core_hold", 32'(core_hold_o), 32'd0);
        check("img1_busy", 32'(busy_o), 32'd0);
        byte_valid_i = 1'b1;
        repeat (2) @(negedge CLK);
        byte_valid_i = 1'b0;
        check("done_ignores_valid_ready", 32'(byte_ready_o), 32'd0);
        check("done_ignores_valid_done", 32'(done_o), 32'd1);

        // Zero-length image
        pulse_start();
        check("restart_core_hold", 32'(core_hold_o), 32'd1);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("len0_done", 32'(done_o), 32'd1);
        check("len0_busy", 32'(busy_o), 32'd0);

        // Oversize count, then recovery (start while busy must be ignored)
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h10, 0);
        check("oversize_error", 32'(error_o), 32'd1);
        check("oversize_core_hold", 32'(core_hold_o), 32'd1);
        check("oversize_busy", 32'(busy_o), 32'd0);
        expect_write(12'd0, 32'hDDCCBBAA);
        pulse_start();
        check("recover_error_clr", 32'(error_o), 32'd0);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'hAA, 0);
        pulse_start();
        check("busy_start_ignored", 32'(busy_o), 32'd1);
        send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'h01, 0);
`else
        @(negedge CLK);
`endif
        check("recover_done", 32'(done_o), 32'd1);

        // Reset mid-load with gappy stream
        pulse_start();
        send_byte(8'h01, 2); send_byte(8'h00, 2);
        send_byte(8'h11, 3); send_byte(8'h22, 3);
        RST = 1'b0;
        #1;
        check("midrst_ready", 32'(byte_ready_o), 32'd0);
        check("midrst_core_hold", 32'(core_hold_o), 32'd1);
        check("midrst_flags", {29'd0, busy_o, done_o, error_o}, 32'd0);
        check("midrst_addr", 32'(mem_addr_o), 32'd0);
        check("midrst_data", mem_data_o, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("midrst_we", 32'(mem_we_o), 32'd0);
        check("midrst_idle_hold", 32'(core_hold_o), 32'd1);

`ifdef INST_LOADER_CHECKSUM_EN
        // Checksum good then bad
        expect_write(12'd0, 32'h44332211);
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h45, 0);
        check("chk_good_done", 32'(done_o), 32'd1);
        expect_write(12'd0, 32'h44332211);
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h00, 0);
        check("chk_bad_error", 32'(error_o), 32'd1);
        check("chk_bad_core_hold", 32'(core_hold_o), 32'd1);
`endif

        repeat (3) @(negedge CLK);
        check("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
